// File: rtl/perf_event_monitor.sv
// Performance counter bank: cycles, retired instructions and NUM_CH event lines,
// frozen on halt, read through a one-cycle registered select port.
// Optional build macro PERF_SATURATE_EN: counters saturate at all-ones instead of wrapping.
module perf_event_monitor #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CNT_W  = 32,
    parameter int unsigned SEL_W  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                retire,
    input  logic [NUM_CH-1:0]   event_in,
    input  logic                halt,
    input  logic                clear,
    input  logic                rd_req,
    input  logic [SEL_W-1:0]    rd_sel,
    output logic                rd_valid,
    output logic [CNT_W-1:0]    rd_data,
    output logic                rd_err,
    output logic [NUM_CH+1:0]   ovf,
    output logic                halted
);

    localparam int unsigned NUM_CNT = NUM_CH + 2;

    typedef enum logic {
        RUN,
        HALTED
    } state_t;

    state_t             state;
    logic [CNT_W-1:0]   cnt [NUM_CNT];
    logic [NUM_CNT-1:0] inc_c;
    logic [CNT_W-1:0]   sel_data_c;
    logic               sel_bad_c;

    // Increment strobes in read-index order: cycles, instructions, events.
    always_comb begin
        inc_c = {event_in, retire, 1'b1};
    end

    always_comb begin
        sel_data_c = '0;
        for (int i = 0; i < int'(NUM_CNT); i++) begin
            if (rd_sel == SEL_W'(i)) begin
                sel_data_c = cnt[i];
            end
        end
        sel_bad_c = (rd_sel > SEL_W'(NUM_CNT - 1));
    end

    // Counters, overflow flags and run/halt state.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            ovf   <= '0;
            for (int i = 0; i < int'(NUM_CNT); i++) begin
                cnt[i] <= '0;
            end
        end else if (clear) begin
            state <= RUN;
            ovf   <= '0;
            for (int i = 0; i < int'(NUM_CNT); i++) begin
                cnt[i] <= '0;
            end
        end else if (state == RUN) begin
            for (int i = 0; i < int'(NUM_CNT); i++) begin
                if (inc_c[i]) begin
                    if (&cnt[i]) begin
                        ovf[i] <= 1'b1;
`ifdef PERF_SATURATE_EN
                        cnt[i] <= cnt[i];
`else
                        cnt[i] <= '0;
`endif
                    end else begin
                        cnt[i] <= cnt[i] + CNT_W'(1);
                    end
                end
            end
            if (halt) begin
                state <= HALTED;
            end
        end
    end

    // Read port samples counters before this edge's update.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_valid <= 1'b0;
            rd_data  <= '0;
            rd_err   <= 1'b0;
        end else begin
            rd_valid <= rd_req;
            if (rd_req) begin
                rd_data <= sel_bad_c ? '0 : sel_data_c;
                rd_err  <= sel_bad_c;
            end
        end
    end

    assign halted = (state == HALTED);

endmodule
